// File: rtl/usb_command_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : usb_command_decoder                                           |
// | Purpose  : Assembles bytes from the USB FIFO read sequencer into cube    |
// |            commands: voxel colour writes into the back frame buffer,     |
// |            front/back bank swaps and panel-switch report requests.       |
// | Ports    : clk, reset_n (async, active low)                              |
// |            data_in[7:0], byte_valid  - byte stream from the sequencer    |
// |            panel_done                - panel report write completed      |
// |            mem_wr_en, mem_addr[12:0], mem_data[23:0] - frame-buffer port |
// |            front_bank                - bank currently displayed          |
// |            panel_select_request      - level request to the sequencer    |
// |            error_count[7:0]          - saturating protocol error count   |
// |            state_out[2:0]            - FSM state, debug only             |
// | Config   : CMD_TIMEOUT_EN - when defined, abandons a packet whose        |
// |            inter-byte gap reaches TIMEOUT_CYCLES and counts an error.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module usb_command_decoder #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  data_in,
    input  logic        byte_valid,
    input  logic        panel_done,
    output logic        mem_wr_en,
    output logic [12:0] mem_addr,
    output logic [23:0] mem_data,
    output logic        front_bank,
    output logic        panel_select_request,
    output logic [7:0]  error_count,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_HI = 3'd1,
        S_ADDR_LO = 3'd2,
        S_RED     = 3'd3,
        S_GREEN   = 3'd4,
        S_BLUE    = 3'd5
    } state_t;

    localparam logic [7:0] c_OP_WRITE = 8'h01;
    localparam logic [7:0] c_OP_SWAP  = 8'h02;
    localparam logic [7:0] c_OP_PANEL = 8'h03;

    state_t      r_state;
    logic [3:0]  r_addr_hi;
    logic [7:0]  r_addr_lo;
    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic        r_mem_wr_en;
    logic [12:0] r_mem_addr;
    logic [23:0] r_mem_data;
    logic        r_front;
    logic        r_panel;
    logic [7:0]  r_err;

    state_t      w_cur_state;
    state_t      w_state_nxt;
    logic [3:0]  w_addr_hi_nxt;
    logic [7:0]  w_addr_lo_nxt;
    logic [7:0]  w_red_nxt;
    logic [7:0]  w_green_nxt;
    logic        w_wr_nxt;
    logic [12:0] w_mem_addr_nxt;
    logic [23:0] w_mem_data_nxt;
    logic        w_front_nxt;
    logic        w_panel_set;
    logic [1:0]  w_err_inc;
    logic [8:0]  w_err_sum;
    logic [7:0]  w_err_nxt;
    logic        w_timeout;

`ifdef CMD_TIMEOUT_EN
    // Idle-gap counter: counts cycles without an accepted byte while a packet
    // is in progress; cleared by every accepted byte and whenever the FSM
    // lands back in IDLE.
    logic [23:0] r_gap_cnt;

    assign w_timeout = (r_state != S_IDLE) && (r_gap_cnt >= TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gap_cnt <= 24'd0;
        end else if (byte_valid || (w_state_nxt == S_IDLE)) begin
            r_gap_cnt <= 24'd0;
        end else begin
            r_gap_cnt <= r_gap_cnt + 24'd1;
        end
    end
`else
    // No gap counter: a packet waits indefinitely for its remaining bytes.
    logic [23:0] w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = TIMEOUT_CYCLES;
`endif

    // Next-state and next-output logic. A timeout collapses the current state
    // to IDLE first, so a byte arriving in that same cycle is decoded as an
    // opcode.
    always_comb begin
        w_cur_state    = w_timeout ? S_IDLE : r_state;
        w_state_nxt    = w_cur_state;
        w_addr_hi_nxt  = r_addr_hi;
        w_addr_lo_nxt  = r_addr_lo;
        w_red_nxt      = r_red;
        w_green_nxt    = r_green;
        w_wr_nxt       = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_data_nxt = r_mem_data;
        w_front_nxt    = r_front;
        w_panel_set    = 1'b0;
        w_err_inc      = {1'b0, w_timeout};

        case (w_cur_state)
            S_IDLE: begin
                if (byte_valid) begin
                    case (data_in)
                        c_OP_WRITE: w_state_nxt = S_ADDR_HI;
                        c_OP_SWAP:  w_front_nxt = ~r_front;
                        c_OP_PANEL: w_panel_set = 1'b1;
                        default:    w_err_inc   = w_timeout ? 2'd2 : 2'd1;
                    endcase
                end
            end
            S_ADDR_HI: begin
                if (byte_valid) begin
                    // Upper nibble of the high address byte is don't-care.
                    w_addr_hi_nxt = data_in[3:0];
                    w_state_nxt   = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (byte_valid) begin
                    w_addr_lo_nxt = data_in;
                    w_state_nxt   = S_RED;
                end
            end
            S_RED: begin
                if (byte_valid) begin
                    w_red_nxt   = data_in;
                    w_state_nxt = S_GREEN;
                end
            end
            S_GREEN: begin
                if (byte_valid) begin
                    w_green_nxt = data_in;
                    w_state_nxt = S_BLUE;
                end
            end
            S_BLUE: begin
                if (byte_valid) begin
                    // Bank is captured here, so a later swap cannot redirect
                    // a write that has already been issued.
                    w_wr_nxt       = 1'b1;
                    w_mem_addr_nxt = {~r_front, r_addr_hi, r_addr_lo};
                    w_mem_data_nxt = {r_red, r_green, data_in};
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                // Encodings 6 and 7 are unreachable; recover to IDLE.
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // At most two errors per cycle (timeout plus a bad opcode); clamp at 255.
    assign w_err_sum = {1'b0, r_err} + {7'd0, w_err_inc};
    assign w_err_nxt = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_addr_hi   <= 4'd0;
            r_addr_lo   <= 8'd0;
            r_red       <= 8'd0;
            r_green     <= 8'd0;
            r_mem_wr_en <= 1'b0;
            r_mem_addr  <= 13'd0;
            r_mem_data  <= 24'd0;
            r_front     <= 1'b0;
            r_panel     <= 1'b0;
            r_err       <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr_hi   <= w_addr_hi_nxt;
            r_addr_lo   <= w_addr_lo_nxt;
            r_red       <= w_red_nxt;
            r_green     <= w_green_nxt;
            r_mem_wr_en <= w_wr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_data  <= w_mem_data_nxt;
            r_front     <= w_front_nxt;
            // A new request beats a simultaneous completion.
            if (w_panel_set) begin
                r_panel <= 1'b1;
            end else if (panel_done) begin
                r_panel <= 1'b0;
            end
            r_err       <= w_err_nxt;
        end
    end

    assign mem_wr_en            = r_mem_wr_en;
    assign mem_addr             = r_mem_addr;
    assign mem_data             = r_mem_data;
    assign front_bank           = r_front;
    assign panel_select_request = r_panel;
    assign error_count          = r_err;
    assign state_out            = r_state;

endmodule
`default_nettype wire

// File: tb/tb_usb_command_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_usb_command_decoder                                        |
// | Purpose  : Self-checking bench for usb_command_decoder. A packet-level   |
// |            reference model (byte queue per packet) predicts every output |
// |            each cycle; a vector table and directed sequences add explicit |
// |            expectations for the documented scenarios.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_usb_command_decoder;

    localparam logic [23:0] c_TIMEOUT = 24'd16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        panel_done = 1'b0;
    logic        mem_wr_en;
    logic [12:0] mem_addr;
    logic [23:0] mem_data;
    logic        front_bank;
    logic        panel_select_request;
    logic [7:0]  error_count;
    logic [2:0]  state_out;

    always #5 clk = ~clk;

    usb_command_decoder #(.TIMEOUT_CYCLES(c_TIMEOUT)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .data_in              (data_in),
        .byte_valid           (byte_valid),
        .panel_done           (panel_done),
        .mem_wr_en            (mem_wr_en),
        .mem_addr             (mem_addr),
        .mem_data             (mem_data),
        .front_bank           (front_bank),
        .panel_select_request (panel_select_request),
        .error_count          (error_count),
        .state_out            (state_out)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model (packet level) ----------------
    logic [7:0]  m_q[$];
    logic        m_front, m_panel, m_wr;
    logic [12:0] m_addr;
    logic [23:0] m_data;
    int          m_err, m_gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_front = 1'b0; m_panel = 1'b0; m_wr = 1'b0;
        m_addr = 13'd0; m_data = 24'd0; m_err = 0; m_gap = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic done);
        logic set_panel;
        set_panel = 1'b0;
        m_wr = 1'b0;
`ifdef CMD_TIMEOUT_EN
        if (m_q.size() != 0 && m_gap >= int'(c_TIMEOUT)) begin
            m_q.delete();
            m_err = (m_err < 255) ? m_err + 1 : 255;
        end
`endif
        if (v) begin
            if (m_q.size() == 0) begin
                case (d)
                    8'h01:   m_q.push_back(d);
                    8'h02:   m_front = ~m_front;
                    8'h03:   set_panel = 1'b1;
                    default: m_err = (m_err < 255) ? m_err + 1 : 255;
                endcase
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 6) begin
                    m_addr = {~m_front, m_q[1][3:0], m_q[2]};
                    m_data = {m_q[3], m_q[4], m_q[5]};
                    m_wr   = 1'b1;
                    m_q.delete();
                end
            end
        end
        if (set_panel) m_panel = 1'b1;
        else if (done) m_panel = 1'b0;
        m_gap = (v || m_q.size() == 0) ? 0 : m_gap + 1;
    endtask

    task automatic check_model();
        check("mdl_wr",    32'(mem_wr_en),            32'(m_wr));
        check("mdl_addr",  32'(mem_addr),             32'(m_addr));
        check("mdl_data",  32'(mem_data),             32'(m_data));
        check("mdl_front", 32'(front_bank),           32'(m_front));
        check("mdl_panel", 32'(panel_select_request), 32'(m_panel));
        check("mdl_err",   32'(error_count),          32'(m_err));
        check("mdl_state", 32'(state_out),            32'(m_q.size()));
    endtask

    // One clock: inputs set on the falling edge, outputs compared 1 ns after
    // the rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic done);
        @(negedge clk);
        byte_valid = v; data_in = d; panel_done = done;
        @(posedge clk);
        model_step(v, d, done);
        #1;
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr"},    32'(mem_wr_en),            32'd0);
        check({tag, "_addr"},  32'(mem_addr),             32'd0);
        check({tag, "_data"},  32'(mem_data),             32'd0);
        check({tag, "_front"}, 32'(front_bank),           32'd0);
        check({tag, "_panel"}, 32'(panel_select_request), 32'd0);
        check({tag, "_err"},   32'(error_count),          32'd0);
        check({tag, "_state"}, 32'(state_out),            32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        byte_valid = 1'b0; data_in = 8'h00; panel_done = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic send_write(input logic [7:0] ah, input logic [7:0] al,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, ah, 1'b0);
        step(1'b1, al, 1'b0);
        step(1'b1, r, 1'b0);
        step(1'b1, g, 1'b0);
        step(1'b1, b, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        done;
        logic        wr;
        logic [12:0] addr;
        logic [23:0] data;
        logic        front;
        logic        panel;
        logic [7:0]  err;
        logic [2:0]  st;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int wr_cnt;
        int idx_a, idx_b;
        logic [7:0] bad;

        tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 13'h0000, 24'h000000, 1'b0, 1'b0, 8'd0, 3'd1};
        tbl[1]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 13'h0000, 24'h000000, 1'b0, 1'b0, 8'd0, 3'd2};
        tbl[2]  = '{1'b1, 8'hBC, 1'b0, 1'b0, 13'h0000, 24'h000000, 1'b0, 1'b0, 8'd0, 3'd3};
        tbl[3]  = '{1'b1, 8'h11, 1'b0, 1'b0, 13'h0000, 24'h000000, 1'b0, 1'b0, 8'd0, 3'd4};
        tbl[4]  = '{1'b1, 8'h22, 1'b0, 1'b0, 13'h0000, 24'h000000, 1'b0, 1'b0, 8'd0, 3'd5};
        tbl[5]  = '{1'b1, 8'h33, 1'b0, 1'b1, 13'h1ABC, 24'h112233, 1'b0, 1'b0, 8'd0, 3'd0};
        tbl[6]  = '{1'b1, 8'h02, 1'b0, 1'b0, 13'h1ABC, 24'h112233, 1'b1, 1'b0, 8'd0, 3'd0};
        tbl[7]  = '{1'b1, 8'h03, 1'b0, 1'b0, 13'h1ABC, 24'h112233, 1'b1, 1'b1, 8'd0, 3'd0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 13'h1ABC, 24'h112233, 1'b1, 1'b0, 8'd0, 3'd0};
        tbl[9]  = '{1'b1, 8'h03, 1'b1, 1'b0, 13'h1ABC, 24'h112233, 1'b1, 1'b1, 8'd0, 3'd0};
        tbl[10] = '{1'b1, 8'h7F, 1'b0, 1'b0, 13'h1ABC, 24'h112233, 1'b1, 1'b1, 8'd1, 3'd0};
        tbl[11] = '{1'b0, 8'h01, 1'b0, 1'b0, 13'h1ABC, 24'h112233, 1'b1, 1'b1, 8'd1, 3'd0};

        model_reset();
        do_reset();

        // Table vectors, one per clock.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].done);
            check("tbl_wr",    32'(mem_wr_en),            32'(tbl[i].wr));
            check("tbl_addr",  32'(mem_addr),             32'(tbl[i].addr));
            check("tbl_data",  32'(mem_data),             32'(tbl[i].data));
            check("tbl_front", 32'(front_bank),           32'(tbl[i].front));
            check("tbl_panel", 32'(panel_select_request), 32'(tbl[i].panel));
            check("tbl_err",   32'(error_count),          32'(tbl[i].err));
            check("tbl_state", 32'(state_out),            32'(tbl[i].st));
        end

        // Spaced bytes, one every 4 cycles: exactly one write pulse, right
        // after the blue byte.
        do_reset();
        wr_cnt = 0;
        begin
            logic [7:0] pkt [6];
            pkt[0] = 8'h01; pkt[1] = 8'h0A; pkt[2] = 8'hBC;
            pkt[3] = 8'h11; pkt[4] = 8'h22; pkt[5] = 8'h33;
            for (int i = 0; i < 6; i++) begin
                step(1'b1, pkt[i], 1'b0);
                if (mem_wr_en) wr_cnt++;
                if (i == 5) begin
                    check("spaced_wr",   32'(mem_wr_en), 32'd1);
                    check("spaced_addr", 32'(mem_addr),  32'h1ABC);
                    check("spaced_data", 32'(mem_data),  32'h112233);
                end
                for (int k = 0; k < 3; k++) begin
                    step(1'b0, 8'hEE, 1'b0);
                    if (mem_wr_en) wr_cnt++;
                end
            end
        end
        check("spaced_wr_count", 32'(wr_cnt), 32'd1);

        // Two back-to-back packets: pulses six cycles apart.
        idx_a = -1; idx_b = -1;
        begin
            logic [7:0] bb [12];
            bb[0] = 8'h01; bb[1]  = 8'h12; bb[2]  = 8'h34; bb[3]  = 8'h56; bb[4]  = 8'h78; bb[5]  = 8'h9A;
            bb[6] = 8'h01; bb[7]  = 8'h0F; bb[8]  = 8'hFF; bb[9]  = 8'h01; bb[10] = 8'h02; bb[11] = 8'h03;
            for (int i = 0; i < 12; i++) begin
                step(1'b1, bb[i], 1'b0);
                if (mem_wr_en) begin
                    if (idx_a < 0) idx_a = i; else idx_b = i;
                end
                if (i == 5) begin
                    check("b2b_addr0", 32'(mem_addr), 32'h1234);
                    check("b2b_data0", 32'(mem_data), 32'h56789A);
                end
            end
        end
        check("b2b_first_idx",  32'(idx_a), 32'd5);
        check("b2b_second_idx", 32'(idx_b), 32'd11);
        check("b2b_addr1", 32'(mem_addr), 32'h1FFF);
        check("b2b_data1", 32'(mem_data), 32'h010203);

        // Swap, then write: lands in bank 0.
        do_reset();
        step(1'b1, 8'h02, 1'b0);
        check("swap_front", 32'(front_bank), 32'd1);
        send_write(8'h00, 8'h05, 8'hFF, 8'h00, 8'h00);
        check("swap_wr",   32'(mem_wr_en), 32'd1);
        check("swap_addr", 32'(mem_addr),  32'h0005);
        check("swap_data", 32'(mem_data),  32'hFF0000);
        // Swap right after the write leaves the issued write untouched.
        step(1'b1, 8'h02, 1'b0);
        check("swap_after_addr", 32'(mem_addr), 32'h0005);

        // Invalid opcodes saturate the error count; no writes, FSM stays IDLE.
        do_reset();
        wr_cnt = 0;
        step(1'b1, 8'h7F, 1'b0);
        check("err_first", 32'(error_count), 32'd1);
        for (int i = 0; i < 300; i++) begin
            bad = 8'($urandom_range(4, 255));
            step(1'b1, bad, 1'b0);
            if (mem_wr_en) wr_cnt++;
            check("err_state_idle", 32'(state_out), 32'd0);
        end
        check("err_saturated", 32'(error_count), 32'd255);
        check("err_no_writes", 32'(wr_cnt), 32'd0);

        // Reset asserted in the RED state.
        do_reset();
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h05, 1'b0);
        check("red_state", 32'(state_out), 32'd3);
        #2;
        byte_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        check("midrst_no_write", 32'(mem_wr_en), 32'd0);

`ifdef CMD_TIMEOUT_EN
        // Stalled packet times out; the following swap is decoded normally.
        do_reset();
        wr_cnt = 0;
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (mem_wr_en) wr_cnt++;
        end
        check("to_state_idle", 32'(state_out),   32'd0);
        check("to_err",        32'(error_count), 32'd1);
        step(1'b1, 8'h02, 1'b0);
        check("to_swap_front", 32'(front_bank),  32'd1);
        check("to_no_write",   32'(wr_cnt),      32'd0);
`endif

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [7:0] d;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    d = 8'h01;
                2:       d = 8'h02;
                3:       d = 8'h03;
                default: d = 8'($urandom);
            endcase
            if ($urandom_range(0, 99) < 3) begin
                for (int k = 0; k < int'($urandom_range(10, 25)); k++)
                    step(1'b0, 8'h00, ($urandom_range(0, 7) == 0));
            end
            step(($urandom_range(0, 1) == 1), d, ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
